// File: rtl/traffic_light_safety_monitor.sv
// Receive-side safety checker for the four lamp buses. Passes lamp drives through registered
// and forces a flashing-red pattern after the first encoding, conflict, order, dwell or stall violation.
module traffic_light_safety_monitor #(
    parameter int unsigned MIN_Y      = 3,
    parameter int unsigned MAX_ALLRED = 16,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_M1,
    input  logic [2:0] light_M2,
    input  logic [2:0] light_MT,
    input  logic [2:0] light_S,
    input  logic       clr,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_M2,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_S,
    output logic       fault,
    output logic [3:0] fault_code,
    output logic [1:0] fault_lane
);

    localparam int unsigned YW = $clog2(MIN_Y + 2);
    localparam int unsigned AW = $clog2(MAX_ALLRED + 2);
    localparam int unsigned FW = $clog2(FLASH_HALF + 2);

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    localparam logic [3:0] FC_NONE     = 4'd0;
    localparam logic [3:0] FC_ENC      = 4'd1;
    localparam logic [3:0] FC_CONFLICT = 4'd2;
    localparam logic [3:0] FC_TRANS    = 4'd3;
    localparam logic [3:0] FC_SHORT_Y  = 4'd4;
    localparam logic [3:0] FC_STALL    = 4'd5;

    localparam logic [YW-1:0] Y_SAT  = YW'(MIN_Y);
    localparam logic [AW-1:0] A_LIM  = AW'(MAX_ALLRED);
    localparam logic [AW-1:0] A_SAT  = AW'(MAX_ALLRED + 1);
    localparam logic [FW-1:0] F_LAST = FW'(FLASH_HALF - 1);

    // Lane order: 0 M1, 1 M2, 2 MT, 3 S
    logic [2:0]    cur    [4];
    logic [2:0]    prev   [4];
    logic [YW-1:0] ycnt   [4];
    logic [YW-1:0] ycnt_d [4];
    logic [2:0]    lamp_d [4];
    logic [AW-1:0] acnt, acnt_d;
    logic [FW-1:0] hcnt, hcnt_d;
    logic          phase, phase_d;
    logic          fault_d;
    logic [3:0]    code_d;
    logic [1:0]    lane_d;
    logic          all_red, viol;
    logic [3:0]    vcode;
    logic [1:0]    vlane;

    assign cur[0] = light_M1;
    assign cur[1] = light_M2;
    assign cur[2] = light_MT;
    assign cur[3] = light_S;

    function automatic logic is_onehot(input logic [2:0] v);
        return (v == RED) || (v == YEL) || (v == GRN);
    endfunction

    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
        return ((p == GRN) && (c == YEL)) || ((p == YEL) && (c == RED)) ||
               ((p == RED) && (c == GRN));
    endfunction

    // Violation detect; later assignments override, so codes are walked from highest to lowest
    always_comb begin
        all_red = 1'b1;
        vcode   = FC_NONE;
        vlane   = 2'd0;
        for (int i = 0; i < 4; i++) all_red = all_red && (cur[i] == RED);
        if (all_red && (acnt >= A_LIM)) begin
            vcode = FC_STALL;
            vlane = 2'd0;
        end
        for (int i = 3; i >= 0; i--) begin
            if ((prev[i] == YEL) && (cur[i] == RED) && (ycnt[i] < Y_SAT)) begin
                vcode = FC_SHORT_Y;
                vlane = 2'(i);
            end
        end
        for (int i = 3; i >= 0; i--) begin
            if (is_onehot(cur[i]) && (cur[i] != prev[i]) && !legal_step(prev[i], cur[i])) begin
                vcode = FC_TRANS;
                vlane = 2'(i);
            end
        end
        if ((cur[3] != RED) && ((cur[0] != RED) || (cur[1] != RED) || (cur[2] != RED))) begin
            vcode = FC_CONFLICT;
            vlane = 2'd3;
        end
        if ((cur[2] != RED) && (cur[1] != RED)) begin
            vcode = FC_CONFLICT;
            vlane = 2'd2;
        end
        for (int i = 3; i >= 0; i--) begin
            if (!is_onehot(cur[i])) begin
                vcode = FC_ENC;
                vlane = 2'(i);
            end
        end
        viol = (vcode != FC_NONE);
    end

    // Next-state: dwell counters, fault latch, flash timing and lamp drive
    always_comb begin
        fault_d = fault;
        code_d  = fault_code;
        lane_d  = fault_lane;
        hcnt_d  = '0;
        phase_d = 1'b0;
        acnt_d  = '0;
        for (int i = 0; i < 4; i++) begin
            ycnt_d[i] = '0;
            lamp_d[i] = cur[i];
        end

        for (int i = 0; i < 4; i++) begin
            if (cur[i] == YEL) ycnt_d[i] = (ycnt[i] == Y_SAT) ? Y_SAT : ycnt[i] + 1'b1;
        end
        if (all_red) acnt_d = (acnt == A_SAT) ? A_SAT : acnt + 1'b1;

        if (viol && (!fault || clr)) begin
            fault_d = 1'b1;
            code_d  = vcode;
            lane_d  = vlane;
        end else if (clr) begin
            fault_d = 1'b0;
            code_d  = FC_NONE;
            lane_d  = 2'd0;
        end

        // Flash phase restarts on red whenever the fault is newly raised
        if (fault_d && fault) begin
            if (hcnt == F_LAST) begin
                hcnt_d  = '0;
                phase_d = ~phase;
            end else begin
                hcnt_d  = hcnt + 1'b1;
                phase_d = phase;
            end
        end

        if (fault_d) begin
            for (int i = 0; i < 4; i++) lamp_d[i] = phase_d ? DARK : RED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                prev[i] <= RED;
                ycnt[i] <= '0;
            end
            acnt       <= '0;
            hcnt       <= '0;
            phase      <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_lane <= 2'd0;
            lamp_M1    <= RED;
            lamp_M2    <= RED;
            lamp_MT    <= RED;
            lamp_S     <= RED;
        end else begin
            for (int i = 0; i < 4; i++) begin
                prev[i] <= cur[i];
                ycnt[i] <= ycnt_d[i];
            end
            acnt       <= acnt_d;
            hcnt       <= hcnt_d;
            phase      <= phase_d;
            fault      <= fault_d;
            fault_code <= code_d;
            fault_lane <= lane_d;
            lamp_M1    <= lamp_d[0];
            lamp_M2    <= lamp_d[1];
            lamp_MT    <= lamp_d[2];
            lamp_S     <= lamp_d[3];
        end
    end

endmodule

// File: tb/tb_traffic_light_safety_monitor.sv
// Bench for traffic_light_safety_monitor: directed scenarios plus random lamp traffic,
// checked every cycle against a rule-level model of the monitor.
module tb_traffic_light_safety_monitor;

    localparam int MIN_Y      = 3;
    localparam int MAX_ALLRED = 16;
    localparam int FLASH_HALF = 4;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [2:0] lamp_M1, lamp_M2, lamp_MT, lamp_S;
    logic       fault;
    logic [3:0] fault_code;
    logic [1:0] fault_lane;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [2:0] mp [4];
    int         yrun [4];
    int         arun;
    bit         mf;
    int         mcode, mlane, age;
    logic [2:0] exp_lamp [4];

    traffic_light_safety_monitor #(
        .MIN_Y(MIN_Y), .MAX_ALLRED(MAX_ALLRED), .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk(clk), .rst(rst),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .clr(clr),
        .lamp_M1(lamp_M1), .lamp_M2(lamp_M2), .lamp_MT(lamp_MT), .lamp_S(lamp_S),
        .fault(fault), .fault_code(fault_code), .fault_lane(fault_lane)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Colour position in the G->Y->R->G cycle, -1 when not a valid lamp state
    function automatic int cidx(input logic [2:0] v);
        case (v)
            G:       return 0;
            Y:       return 1;
            R:       return 2;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mp[i]       = R;
            yrun[i]     = 0;
            exp_lamp[i] = R;
        end
        arun  = 0;
        mf    = 0;
        mcode = 0;
        mlane = 0;
        age   = 0;
    endtask

    task automatic model_update();
        logic [2:0] l [4];
        int  best;
        bit  allr;
        l[0] = light_M1; l[1] = light_M2; l[2] = light_MT; l[3] = light_S;
        best = 1000;   // violations ranked by code*4+lane, smallest wins
        allr = 1;
        for (int i = 0; i < 4; i++) if (l[i] != R) allr = 0;
        arun = allr ? arun + 1 : 0;
        if (arun > MAX_ALLRED) best = (5 * 4 < best) ? 5 * 4 : best;
        for (int i = 0; i < 4; i++) begin
            if (cidx(l[i]) < 0) begin
                if (4 + i < best) best = 4 + i;
            end else if (l[i] != mp[i] &&
                         !(cidx(mp[i]) >= 0 && cidx(l[i]) == (cidx(mp[i]) + 1) % 3)) begin
                if (12 + i < best) best = 12 + i;
            end
            if (mp[i] == Y && l[i] == R && yrun[i] < MIN_Y && 16 + i < best) best = 16 + i;
            yrun[i] = (l[i] == Y) ? yrun[i] + 1 : 0;
        end
        if (l[3] != R && (l[0] != R || l[1] != R || l[2] != R) && 8 + 3 < best) best = 8 + 3;
        if (l[2] != R && l[1] != R && 8 + 2 < best) best = 8 + 2;

        if (best < 1000 && (!mf || clr)) begin
            age   = mf ? age + 1 : 0;
            mf    = 1;
            mcode = best / 4;
            mlane = best % 4;
        end else if (clr) begin
            mf = 0; mcode = 0; mlane = 0; age = 0;
        end else if (mf) begin
            age++;
        end
        for (int i = 0; i < 4; i++) begin
            exp_lamp[i] = mf ? (((age / FLASH_HALF) % 2 == 0) ? R : 3'b000) : l[i];
            mp[i] = l[i];
        end
    endtask

    task automatic step(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic [2:0] d, input logic cl);
        light_M1 = a; light_M2 = b; light_MT = c; light_S = d; clr = cl;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step_n(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                          input logic [2:0] d, input int n);
        for (int k = 0; k < n; k++) step(a, b, c, d, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0; clr = 1'b0;
        light_M1 = R; light_M2 = R; light_MT = R; light_S = R;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [2:0] advance(input logic [2:0] v);
        case (v)
            G:       return Y;
            Y:       return R;
            R:       return G;
            default: return R;
        endcase
    endfunction

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("lamp_M1", int'(lamp_M1), int'(exp_lamp[0]));
            chk("lamp_M2", int'(lamp_M2), int'(exp_lamp[1]));
            chk("lamp_MT", int'(lamp_MT), int'(exp_lamp[2]));
            chk("lamp_S", int'(lamp_S), int'(exp_lamp[3]));
            chk("fault", int'(fault), int'(mf));
            chk("fault_code", int'(fault_code), mcode);
            chk("fault_lane", int'(fault_lane), mlane);
        end
    end

    initial begin
        logic [2:0] v [4];
        do_reset();
        chk("rst lamp_M1", int'(lamp_M1), 4);
        chk("rst lamp_S", int'(lamp_S), 4);
        chk("rst fault", int'(fault), 0);
        chk("rst code", int'(fault_code), 0);

        // Legal full cycle, three times
        for (int rep = 0; rep < 3; rep++) begin
            step_n(G, G, R, R, 5); step_n(Y, Y, R, R, 3);
            step_n(R, R, G, R, 5); step_n(R, R, Y, R, 3);
            step_n(R, R, R, G, 5); step_n(R, R, R, Y, 3);
        end
        chk("legal fault", int'(fault), 0);
        chk("legal lamp_S", int'(lamp_S), 2);

        // Conflict S+M1, flash pattern, clear
        do_reset();
        step(G, R, R, G, 1'b0);
        chk("conf fault", int'(fault), 1);
        chk("conf code", int'(fault_code), 2);
        chk("conf lane", int'(fault_lane), 3);
        for (int k = 0; k < 8; k++) begin
            chk("flash M1", int'(lamp_M1), (k < 4) ? 4 : 0);
            chk("flash S", int'(lamp_S), (k < 4) ? 4 : 0);
            step(R, R, R, R, 1'b0);
        end
        step(R, R, R, G, 1'b1);
        chk("clr fault", int'(fault), 0);
        chk("clr lamp_S", int'(lamp_S), 1);
        step(G, R, R, G, 1'b0);
        step(G, R, R, G, 1'b1);
        chk("clr+conf fault", int'(fault), 1);
        chk("clr+conf code", int'(fault_code), 2);
        step_n(G, R, R, G, 2);
        #2 rst = 1'b0;
        #1;
        chk("async lamp_M1", int'(lamp_M1), 4);
        chk("async lamp_MT", int'(lamp_MT), 4);
        chk("async fault", int'(fault), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Short yellow on M2, then exact minimum dwell
        step(R, G, R, R, 1'b0); step_n(R, Y, R, R, 2); step(R, R, R, R, 1'b0);
        chk("shortY code", int'(fault_code), 4);
        chk("shortY lane", int'(fault_lane), 1);
        do_reset();
        step(R, G, R, R, 1'b0); step_n(R, Y, R, R, 3); step(R, R, R, R, 1'b0);
        chk("minY fault", int'(fault), 0);

        // Bad encoding, alone and beside an illegal transition
        do_reset();
        step(R, R, 3'b011, R, 1'b0);
        chk("enc code", int'(fault_code), 1);
        chk("enc lane", int'(fault_lane), 2);
        do_reset();
        step(R, R, R, G, 1'b0); step(R, R, 3'b011, R, 1'b0);
        chk("enc prio code", int'(fault_code), 1);

        // All-red stall boundary
        do_reset();
        step_n(R, R, R, R, 16);
        chk("red16 fault", int'(fault), 0);
        step(R, R, R, R, 1'b0);
        chk("red17 fault", int'(fault), 1);
        chk("red17 code", int'(fault_code), 5);
        do_reset();
        step_n(R, R, R, R, 16); step(G, R, R, R, 1'b0);
        chk("red16+G fault", int'(fault), 0);

        // Random traffic, mostly legal steps with occasional garbage and clears
        do_reset();
        for (int i = 0; i < 4; i++) v[i] = R;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 2) v[i] = 3'($urandom_range(0, 7));
                else if (r < 25) v[i] = advance(v[i]);
            end
            step(v[0], v[1], v[2], v[3], ($urandom_range(0, 7) == 0));
            if (n % 1000 == 999) begin
                do_reset();
                for (int i = 0; i < 4; i++) v[i] = R;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
